// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch unit.
package fetch_pkg;

  localparam logic [31:0] RESET_PC    = 32'hBFC00000;
  localparam logic [19:0] ROM_BASE_HI = 20'hBFC00;
  localparam logic [31:0] NOP_INSTR   = 32'h00000013;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc;
    logic        fault;
  } fetch_entry_t;

  typedef enum logic {
    FETCH,
    HALTED
  } fetch_state_t;

endpackage

// File: rtl/fetch_queue.sv
// Synchronous FIFO of fetch entries; head is read straight from register storage.
module fetch_queue
  import fetch_pkg::*;
#(
  parameter int unsigned DEPTH = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         flush,
  input  logic         push,
  input  fetch_entry_t push_data,
  input  logic         pop,
  output fetch_entry_t head,
  output logic         empty,
  output logic         full
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [AW:0] FULL_CNT = (AW + 1)'(DEPTH);

  fetch_entry_t   mem [DEPTH];
  logic [AW-1:0]  wr_ptr;
  logic [AW-1:0]  rd_ptr;
  logic [AW:0]    count;
  logic           do_push;
  logic           do_pop;

  always_comb begin
    empty   = (count == '0);
    full    = (count == FULL_CNT);
    do_pop  = pop & ~empty;
    // a full queue still accepts a push when the head leaves in the same cycle
    do_push = push & (~full | do_pop);
  end

  assign head = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/instr_fetch_unit.sv
// Program counter, fetch FSM and range/alignment fault check feeding the fetch queue.
module instr_fetch_unit #(
  parameter logic [31:0] RESET_PC    = fetch_pkg::RESET_PC,
  parameter logic [19:0] ROM_BASE_HI = fetch_pkg::ROM_BASE_HI,
  parameter int unsigned FQ_DEPTH    = 2
) (
  input  logic        clk,
  input  logic        rst,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_instr,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_instr,
  output logic [31:0] out_pc,
  output logic        out_fault,
  output logic        busy
);

  import fetch_pkg::*;

  fetch_state_t state, state_next;
  logic [31:0]  pc, pc_next;
  logic         fault_now;
  logic         pop;
  logic         space;
  logic         push;
  logic         q_empty;
  logic         q_full;
  fetch_entry_t push_data;
  fetch_entry_t head;

  assign imem_addr = pc;
  assign busy      = (state == FETCH);

  always_comb begin
    fault_now = (pc[31:12] != ROM_BASE_HI) | (pc[1:0] != 2'b00);
    pop       = out_valid & out_ready;
    space     = ~q_full | pop;
    push      = (state == FETCH) & ~redirect_valid & space;
    push_data = '{instr: (fault_now ? NOP_INSTR : imem_instr),
                  pc:    pc,
                  fault: fault_now};
  end

  always_comb begin
    state_next = state;
    pc_next    = pc;
    if (redirect_valid) begin
      state_next = FETCH;
      pc_next    = redirect_pc;
    end else begin
      case (state)
        FETCH: begin
          // a faulted fetch parks the PC on the offending address
          if (push) begin
            if (fault_now) state_next = HALTED;
            else           pc_next    = pc + 32'd4;
          end
        end
        HALTED:  state_next = HALTED;
        default: state_next = FETCH;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= FETCH;
      pc    <= RESET_PC;
    end else begin
      state <= state_next;
      pc    <= pc_next;
    end
  end

  fetch_queue #(
    .DEPTH(FQ_DEPTH)
  ) u_queue (
    .clk      (clk),
    .rst      (rst),
    .flush    (redirect_valid),
    .push     (push),
    .push_data(push_data),
    .pop      (pop),
    .head     (head),
    .empty    (q_empty),
    .full     (q_full)
  );

  assign out_valid = ~q_empty;
  assign out_instr = head.instr;
  assign out_pc    = head.pc;
  assign out_fault = head.fault;

endmodule

// File: doc/instr_fetch_unit.md
Name: instr_fetch_unit

Overview:
Owns the program counter and sequences reads of the combinational instruction ROM, which maps 0xBFC00000–0xBFC00FFF. Each fetched word, with its PC and a fault flag, goes into a small fetch queue. The queue drains to decode over a valid/ready handshake. Branch/jump redirects from execute flush the queue and restart fetch. Out-of-range or misaligned PCs produce a faulted entry and halt fetch until the next redirect.

Parameters:
RESET_PC, 32'hBFC00000, PC value loaded on reset
ROM_BASE_HI, 20'hBFC00, required PC[31:12] for a valid ROM address
FQ_DEPTH, 2, fetch queue entries (power of two, >=2)

Ports:
clk  in  1  system clock, rising edge
rst  in  1  synchronous, active-high reset
imem_addr  out  32  address to instruction ROM (combinational read, same-cycle data)
imem_instr  in  32  little-endian word returned by ROM for imem_addr
redirect_valid  in  1  one-cycle pulse: flush and restart fetch at redirect_pc
redirect_pc  in  32  new fetch PC
out_valid  out  1  queue head valid
out_ready  in  1  decode accepts head this cycle
out_instr  out  32  head instruction (32'h00000013 NOP when out_fault=1)
out_pc  out  32  PC of head instruction
out_fault  out  1  head entry is a fetch fault (range or alignment)
busy  out  1  state==FETCH

Behaviour:
- Reset (rst=1 at posedge): pc<=RESET_PC, queue empty, state<=FETCH. Outputs after reset: out_valid=0, out_fault=0, out_instr=0, out_pc=0, busy=1, imem_addr=RESET_PC. rst mid-operation discards all entries and pending redirect.
- imem_addr = pc combinationally, always driven, including in HALTED.
- fault_now = (pc[31:12]!=ROM_BASE_HI) | (pc[1:0]!=0).
- States: FETCH, HALTED.
- FETCH, no redirect: push when space = (count<FQ_DEPTH) | (out_valid & out_ready). Pushed entry = {fault_now ? NOP : imem_instr, pc, fault_now}. On push: pc<=pc+4 (mod 2^32, so 0xFFFFFFFC wraps to 0). If fault_now, state<=HALTED and pc holds. No push means pc holds.
- HALTED: no pushes; pc holds; queue drains normally. Leave only via redirect or rst.
- Pop: occurs when out_valid & out_ready. Head advances at the next edge.
- Same-cycle push and pop when full is legal; count is unchanged.
- Redirect (highest priority below rst): all queue entries invalidated at the edge, including one that would be pushed or popped that cycle. pc<=redirect_pc, state<=FETCH. First fetch at the new PC happens the cycle after. A pop handshake in the redirect cycle still counts as consumed by decode; the unit does not care.
- Latency: redirect at edge N, first valid new-path entry at out_* in cycle N+1 (after edge N+1). Steady-state throughput is 1 instr/cycle with out_ready held high.
- Queue ordering is strictly FIFO; out_* are registered from queue storage, with no combinational path from imem_instr to out_*.
- out_instr, out_pc, out_fault are don't-care when out_valid=0, but must hold stable while out_valid=1 and out_ready=0.
- Last ROM word 0xBFC00FFC fetches normally; next PC 0xBFC01000 yields a fault entry, then HALTED.

Decomposition:
- Package fetch_pkg:
  - localparams RESET_PC, ROM_BASE_HI, NOP_INSTR=32'h00000013
  - typedef fetch_entry_t struct {instr[31:0], pc[31:0], fault}
  - enum fetch_state_t {FETCH, HALTED}
- Sub-module fetch_queue: parameterised synchronous FIFO of fetch_entry_t with push/pop/flush, full/empty, registered head. Flush has priority over push.
- Top holds PC, FSM, fault check.

Test Plan:
1. Reset, ROM words 0..3 = distinct values, out_ready=1 -> out_pc 0xBFC00000, 0xBFC00004, 0xBFC00008, 0xBFC0000C on consecutive cycles, out_fault=0.
2. out_ready=0 for 5 cycles -> queue fills at FQ_DEPTH, pc stops at RESET_PC+4*FQ_DEPTH, head held stable; out_ready=1 -> no entry lost or duplicated.
3. Redirect to 0xBFC00100 while queue full and out_ready=1 -> old entries never appear after the redirect edge; next out_pc=0xBFC00100.
4. Redirect to 0xBFC00FFC -> entry pc 0xBFC00FFC valid, next entry pc 0xBFC01000 out_fault=1 out_instr=0x00000013, busy=0, no further entries.
5. Redirect to 0xBFC00002 -> single fault entry, HALTED; then redirect to 0xBFC00000 -> normal fetch resumes.
6. Assert rst mid-stream with queue non-empty -> next cycle out_valid=0, imem_addr=0xBFC00000, fetch restarts from RESET_PC.
